// File: rtl/axis_gain_pkg.sv
// Shared types and helpers for the multichannel AXI-Stream gain stage.
package axis_gain_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_CLIP   = 2'b01,
        MODE_RECT   = 2'b10,
        MODE_MUTE   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        RECV,
        CALC,
        SEND
    } state_e;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// Synchronises the switch-driven target gain and ramps the current gain
// toward it by a bounded step on each update strobe.
module gain_ramp
    import axis_gain_pkg::*;
#(
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GAIN_WIDTH-1:0] gain_i,
    input  logic                  mute_i,
    input  logic                  upd_i,
    output logic [GAIN_WIDTH-1:0] gain_cur_o
);

    localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);

    logic [GAIN_WIDTH-1:0] gain_s1_q;
    logic [GAIN_WIDTH-1:0] gain_s2_q;
    logic [GAIN_WIDTH-1:0] cur_q;
    logic [GAIN_WIDTH-1:0] cur_d;
    logic [GAIN_WIDTH-1:0] target;
    logic [GAIN_WIDTH-1:0] diff;
    logic [GAIN_WIDTH-1:0] step;

    always_comb begin
        target = mute_i ? '0 : gain_s2_q;
        diff   = (target > cur_q) ? (target - cur_q) : (cur_q - target);
        step   = (diff > STEP) ? STEP : diff;
        cur_d  = cur_q;
        if (upd_i) begin
            cur_d = (target > cur_q) ? (cur_q + step) : (cur_q - step);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gain_s1_q <= '0;
            gain_s2_q <= '0;
            cur_q     <= '0;
        end else begin
            gain_s1_q <= gain_i;
            gain_s2_q <= gain_s1_q;
            cur_q     <= cur_d;
        end
    end

    assign gain_cur_o = cur_q;

endmodule

// File: rtl/axis_multichannel_gain.sv
// N-channel AXI-Stream gain stage: buffers a frame, applies a ramped gain with
// saturation and optional shaping through one shared multiplier, re-emits it.
module axis_multichannel_gain
    import axis_gain_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 2,
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 4,
    parameter int CLIP_SHIFT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GAIN_WIDTH-1:0] gain_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] s_axis_data_i,
    input  logic                  s_axis_valid_i,
    output logic                  s_axis_ready_o,
    input  logic                  s_axis_last_i,
    output logic [DATA_WIDTH-1:0] m_axis_data_o,
    output logic                  m_axis_valid_o,
    input  logic                  m_axis_ready_i,
    output logic                  m_axis_last_o,
    output logic                  frame_err_o,
    output logic [GAIN_WIDTH-1:0] gain_cur_o
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(CHANNELS + 3);
    localparam logic signed [DATA_WIDTH-1:0] S_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] CLIP_T = S_MAX >>> CLIP_SHIFT;

    state_e                       state_q;
    logic [IW-1:0]                idx_q;
    logic [CW-1:0]                cnt_q;
    logic signed [DATA_WIDTH-1:0] buf_q [CHANNELS];
    logic [1:0]                   mode_s1_q;
    logic [1:0]                   mode_s2_q;
    mode_e                        mode_q;
    logic signed [PW-1:0]         p_q;
    logic                         s1_vld_q;
    logic [IW-1:0]                s1_idx_q;
    logic                         s_ready_q;
    logic                         m_valid_q;
    logic                         m_last_q;
    logic [DATA_WIDTH-1:0]        m_data_q;
    logic                         ferr_q;

    logic                         upd;
    logic                         s_hs;
    logic                         m_hs;
    logic [GAIN_WIDTH-1:0]        gain_cur;
    logic [IW-1:0]                issue_idx;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         shifted;
    logic signed [DATA_WIDTH-1:0] sat;
    logic signed [DATA_WIDTH-1:0] shaped;

    assign s_hs = s_ready_q & s_axis_valid_i;
    assign m_hs = m_valid_q & m_axis_ready_i;
    assign upd  = (state_q == CALC) && (cnt_q == '0);

    gain_ramp #(
        .GAIN_WIDTH (GAIN_WIDTH),
        .RAMP_STEP  (RAMP_STEP)
    ) u_ramp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .gain_i     (gain_i),
        .mute_i     (mode_e'(mode_s2_q) == MODE_MUTE),
        .upd_i      (upd),
        .gain_cur_o (gain_cur)
    );

    // CALC cycle 1..CHANNELS issues channel cnt-1 into the multiplier.
    assign issue_idx = IW'(cnt_q - CW'(1));
    assign prod      = PW'(buf_q[issue_idx]) * PW'($signed({1'b0, gain_cur}));
    assign shifted   = p_q >>> (GAIN_WIDTH - 1);
    assign sat       = DATA_WIDTH'(saturate(64'(shifted), DATA_WIDTH));

    always_comb begin
        shaped = sat;
        case (mode_q)
            MODE_CLIP: begin
                if (sat > CLIP_T)       shaped = CLIP_T;
                else if (sat < -CLIP_T) shaped = -CLIP_T;
            end
            MODE_RECT: begin
                if (sat == S_MIN)               shaped = S_MAX;
                else if (sat[DATA_WIDTH-1])     shaped = -sat;
            end
            default: shaped = sat;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RECV;
            idx_q     <= '0;
            cnt_q     <= '0;
            mode_s1_q <= '0;
            mode_s2_q <= '0;
            mode_q    <= MODE_NORMAL;
            p_q       <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            ferr_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) buf_q[i] <= '0;
        end else begin
            mode_s1_q <= mode_i;
            mode_s2_q <= mode_s1_q;
            ferr_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            // Results overwrite the input slot they were computed from.
            if (s1_vld_q) buf_q[s1_idx_q] <= shaped;
            case (state_q)
                RECV: begin
                    s_ready_q <= 1'b1;
                    if (s_hs) begin
                        buf_q[idx_q] <= s_axis_data_i;
                        if (idx_q == IW'(CHANNELS - 1)) begin
                            state_q   <= CALC;
                            cnt_q     <= '0;
                            idx_q     <= '0;
                            s_ready_q <= 1'b0;
                            ferr_q    <= ~s_axis_last_i;
                        end else if (s_axis_last_i) begin
                            idx_q  <= '0;
                            ferr_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '0) mode_q <= mode_e'(mode_s2_q);
                    if (cnt_q >= CW'(1) && cnt_q <= CW'(CHANNELS)) begin
                        s1_vld_q <= 1'b1;
                        s1_idx_q <= issue_idx;
                        p_q      <= prod;
                    end
                    if (cnt_q == CW'(CHANNELS + 2)) begin
                        state_q   <= SEND;
                        idx_q     <= '0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= buf_q[0];
                        m_last_q  <= (CHANNELS == 1);
                    end
                end
                SEND: begin
                    if (m_hs) begin
                        if (idx_q == IW'(CHANNELS - 1)) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            state_q   <= RECV;
                            s_ready_q <= 1'b1;
                            idx_q     <= '0;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            m_data_q <= buf_q[idx_q + 1'b1];
                            m_last_q <= ((idx_q + 1'b1) == IW'(CHANNELS - 1));
                        end
                    end
                end
                default: state_q <= RECV;
            endcase
        end
    end

    assign s_axis_ready_o = s_ready_q;
    assign m_axis_valid_o = m_valid_q;
    assign m_axis_last_o  = m_last_q;
    assign m_axis_data_o  = m_data_q;
    assign frame_err_o    = ferr_q;
    assign gain_cur_o     = gain_cur;

endmodule

// File: tb/tb_axis_multichannel_gain.sv
// Directed bench for axis_multichannel_gain with an arithmetic reference model
// and an output scoreboard checked on every output handshake.
module tb_axis_multichannel_gain;

    localparam int CH   = 2;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gain;
    logic [1:0]  mode;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        ferr;
    logic [7:0]  gain_cur;

    always #5 clk = ~clk;

    axis_multichannel_gain dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .gain_i         (gain),
        .mode_i         (mode),
        .s_axis_data_i  (s_data),
        .s_axis_valid_i (s_valid),
        .s_axis_ready_o (s_ready),
        .s_axis_last_i  (s_last),
        .m_axis_data_o  (m_data),
        .m_axis_valid_o (m_valid),
        .m_axis_ready_i (m_ready),
        .m_axis_last_o  (m_last),
        .frame_err_o    (ferr),
        .gain_cur_o     (gain_cur)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int          g_set, md_set, m_gain, m_idx;
    logic [23:0] fbuf [CH];
    logic [23:0] exp_d [$];
    bit          exp_l [$];
    logic [23:0] got_d [$];
    bit          got_l [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_out(input logic [23:0] x, input int g, input int md);
        longint v;
        v = longint'($signed(x)) * g;
        v = v >>> 7;
        if (v > 8388607)  v = 8388607;
        if (v < -8388608) v = -8388608;
        if (md == 1) begin
            if (v > 2097151)  v = 2097151;
            if (v < -2097151) v = -2097151;
        end else if (md == 2 && v < 0) begin
            v = (v == -8388608) ? 8388607 : -v;
        end
        return 24'(v);
    endfunction

    function automatic int step_gain(input int cur, input int tgt);
        int d;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (d > STEP) d = STEP;
        return (tgt > cur) ? cur + d : cur - d;
    endfunction

    // Scoreboard: every accepted output word must match the model queue.
    logic [23:0] ed;
    bit          el;
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_d.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data 0x%0h with nothing expected", m_data);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                chk("m_data", m_data, ed);
                chk("m_last", m_last, el);
            end
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end
    end

    task automatic send_word(input logic [23:0] d, input bit l);
        bit hs;
        bit exp_err;
        bit closes;
        hs = 1'b0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            hs = s_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!hs) begin
            chk("s_handshake_timeout", 0, 1);
            return;
        end
        last_hs_cyc = cyc;
        fbuf[m_idx] = d;
        closes  = (m_idx == CH - 1);
        exp_err = (l && m_idx < CH - 1) || (!l && m_idx == CH - 1);
        if (closes) begin
            m_gain = step_gain(m_gain, (md_set == 3) ? 0 : g_set);
            for (int k = 0; k < CH; k++) begin
                exp_d.push_back(model_out(fbuf[k], m_gain, md_set));
                exp_l.push_back(k == CH - 1);
            end
            m_idx = 0;
        end else if (l) begin
            m_idx = 0;
        end else begin
            m_idx++;
        end
        @(negedge clk);
        chk("frame_err", ferr, exp_err);
        if (closes) chk("s_ready_after_close", s_ready, 0);
    endtask

    task automatic send_frame(input logic [23:0] d0, input logic [23:0] d1);
        send_word(d0, 1'b0);
        send_word(d1, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", n < 100, 1);
        chk("exp_queue_drained", exp_d.size(), 0);
    endtask

    task automatic set_cfg(input int g, input int md);
        gain   = 8'(g);
        mode   = 2'(md);
        g_set  = g;
        md_set = md;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_and_check(input logic [23:0] d0, input logic [23:0] d1);
        send_frame(d0, d1);
        wait_idle();
        chk("gain_cur_model", gain_cur, m_gain);
    endtask

    task automatic settle();
        for (int i = 0; i < 45 && m_gain != ((md_set == 3) ? 0 : g_set); i++)
            frame_and_check(24'($urandom), 24'($urandom));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid_within_bound", n < 50, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        rst = 1'b1; gain = 8'h80; mode = 2'b00;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        g_set = 128; md_set = 0; m_gain = 0; m_idx = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_err", ferr, 0);
        chk("rst_gain_cur", gain_cur, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_release", s_ready, 1);

        // Ramp from mute to unity
        for (int f = 1; f <= 34; f++) begin
            frame_and_check(24'h400000, 24'($urandom));
            if (f == 1) begin
                chk("ramp_f1_gain", gain_cur, 4);
                chk("ramp_f1_out", got_d[got_d.size()-2], 24'h020000);
            end
            if (f == 2) chk("ramp_f2_gain", gain_cur, 8);
        end
        chk("ramp_hold_gain", gain_cur, 128);

        // Unity gain and latency
        send_frame(24'h100000, 24'hF00000);
        lat = 0;
        wait_valid();
        lat = cyc - last_hs_cyc;
        chk("latency", lat, CH + 3);
        wait_idle();
        chk("unity_w0", got_d[got_d.size()-2], 24'h100000);
        chk("unity_w1", got_d[got_d.size()-1], 24'hF00000);
        chk("unity_last0", got_l[got_l.size()-2], 0);
        chk("unity_last1", got_l[got_l.size()-1], 1);

        // Saturation at maximum gain
        set_cfg(8'hFF, 0);
        settle();
        chk("sat_gain", gain_cur, 8'hFF);
        frame_and_check(24'h600000, 24'hA00000);
        chk("sat_pos", got_d[got_d.size()-2], 24'h7FFFFF);
        chk("sat_neg", got_d[got_d.size()-1], 24'h800000);

        // Shaping at unity
        set_cfg(8'h80, 0);
        settle();
        chk("unity_again", gain_cur, 8'h80);
        set_cfg(8'h80, 1);
        frame_and_check(24'h300000, 24'hD00000);
        chk("clip_pos", got_d[got_d.size()-2], 24'h1FFFFF);
        chk("clip_neg", got_d[got_d.size()-1], 24'hE00001);
        set_cfg(8'h80, 2);
        frame_and_check(24'hF00000, 24'h800000);
        chk("rect_neg", got_d[got_d.size()-2], 24'h100000);
        chk("rect_min", got_d[got_d.size()-1], 24'h7FFFFF);
        set_cfg(8'h80, 3);
        frame_and_check(24'h123456, 24'hFEDCBA);
        chk("mute_g1", gain_cur, 124);
        frame_and_check(24'h123456, 24'hFEDCBA);
        chk("mute_g2", gain_cur, 120);
        frame_and_check(24'h123456, 24'hFEDCBA);
        chk("mute_g3", gain_cur, 116);
        set_cfg(8'h80, 0);

        // Framing errors
        n0 = got_d.size();
        send_word(24'h111111, 1'b1);
        repeat (20) @(negedge clk);
        chk("partial_no_output", got_d.size(), n0);
        frame_and_check(24'h050000, 24'hFB0000);
        chk("good_after_partial", got_d.size(), n0 + 2);
        send_word(24'h000100, 1'b0);
        send_word(24'h000200, 1'b0);
        wait_idle();
        chk("missing_last_emitted", got_d.size(), n0 + 4);

        // Backpressure
        @(posedge clk); #1;
        m_ready = 1'b0;
        send_frame(24'h123456, 24'h654321);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", m_valid, 1);
            chk("bp_data", m_data, exp_d[0]);
            chk("bp_last", m_last, exp_l[0]);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle();

        // Reset during SEND
        @(posedge clk); #1;
        m_ready = 1'b0;
        send_frame(24'h222222, 24'h333333);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_gain", gain_cur, 0);
        chk("rst_mid_s_ready", s_ready, 0);
        exp_d.delete();
        exp_l.delete();
        m_gain = 0;
        m_idx  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_mid_rst", s_ready, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        frame_and_check(24'h400000, 24'h000010);
        chk("post_rst_gain", gain_cur, 4);
        chk("post_rst_out", got_d[got_d.size()-2], 24'h020000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
